// File: rtl/wb_spi_dac_if.sv
// Wishbone pipelined bus bundle for the SPI DAC transmitter.
// Signal names keep the slave-side i_/o_ direction prefixes.
interface wb_spi_dac_if #(
   parameter int WB_ADDR_WIDTH = 2
);
   logic                     i_wb_cyc;
   logic                     i_wb_stb;
   logic                     o_wb_stall;
   logic                     o_wb_ack;
   logic                     i_wb_we;
   logic [WB_ADDR_WIDTH-1:0] i_wb_addr;
   logic [31:0]              i_wb_data;
   logic [3:0]               i_wb_sel;
   logic [31:0]              o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_stall, o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/wb_spi_dac.sv
// Wishbone slave that buffers one 24-bit DAC word and shifts it out as a
// SYNC_n/SCLK/MOSI frame at a programmable SCLK rate.
module wb_spi_dac #(
   parameter int WB_ADDR_WIDTH   = 2,
   parameter int DEFAULT_DIV     = 10,
   parameter int GAP_HALFPERIODS = 6
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   wb_spi_dac_if.slave wb,
   output logic        o_spi_sclk,
   output logic        o_spi_mosi,
   output logic        o_spi_sync_n
);
   localparam int GAP_W = (GAP_HALFPERIODS > 1) ? $clog2(GAP_HALFPERIODS) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

   state_e             state_q, state_d;
   logic               pending_q, pending_d;
   logic [23:0]        data_q, data_d;
   logic [23:0]        shift_q, shift_d;
   logic [7:0]         clkdiv_q, clkdiv_d;
   logic [7:0]         div_q, div_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [4:0]         bits_q, bits_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic               sync_n_q, sync_n_d;
   logic               ack_q, ack_d;
   logic [31:0]        rdata_q, rdata_d;

   logic [WB_ADDR_WIDTH-1:0] addr;
   logic [1:0]               reg_sel;
   logic                     load;
   logic                     tick;
   logic                     accept;
   logic                     wr_data;
   logic                     unused_bits;

   assign addr    = wb.i_wb_addr;
   assign reg_sel = addr[1:0];
   assign load    = (state_q == IDLE) && pending_q;
   assign tick    = (cnt_q == div_q);
   assign accept  = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_stall;
   assign wr_data = accept & wb.i_wb_we & (reg_sel == 2'd0);

   // A DATA write only waits when the buffer is full and not draining this cycle.
   assign wb.o_wb_stall = wb.i_wb_stb & wb.i_wb_we & (reg_sel == 2'd0) & pending_q & ~load;
   assign wb.o_wb_ack   = ack_q;
   assign wb.o_wb_data  = rdata_q;
   assign o_spi_sclk    = sclk_q;
   assign o_spi_mosi    = mosi_q;
   assign o_spi_sync_n  = sync_n_q;

   assign unused_bits = &{1'b0, wb.i_wb_sel, wb.i_wb_data[31:24], addr};

   // Register file and bus response.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      ack_d    = accept;
      rdata_d  = rdata_q;
      data_d   = data_q;
      clkdiv_d = clkdiv_q;
      if (accept && wb.i_wb_we) begin
         case (reg_sel)
            2'd0:    data_d   = wb.i_wb_data[23:0];
            2'd2:    clkdiv_d = wb.i_wb_data[7:0];
            default: ;
         endcase
      end
      if (accept) begin
         case (reg_sel)
            2'd0:    rdata_d = {8'h00, data_q};
            2'd1:    rdata_d = {30'd0, pending_q, state_q != IDLE};
            2'd2:    rdata_d = {24'd0, clkdiv_q};
            default: rdata_d = 32'd0;
         endcase
      end
   end

   // Frame state machine.
   always_comb begin
      state_d   = state_q;
      pending_d = (pending_q & ~load) | wr_data;
      shift_d   = shift_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      bits_d    = bits_q;
      gap_d     = gap_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      sync_n_d  = sync_n_q;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               state_d  = SHIFT;
               shift_d  = data_q;
               div_d    = clkdiv_q;
               sync_n_d = 1'b0;
               mosi_d   = data_q[23];
               sclk_d   = 1'b1;
               bits_d   = 5'd24;
               cnt_d    = 8'd0;
            end
         end
         SHIFT: begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
            if (tick) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  bits_d = bits_q - 5'd1;
               end else begin
                  sclk_d = 1'b1;
                  if (bits_q != 5'd0) begin
                     shift_d = {shift_q[22:0], 1'b0};
                     mosi_d  = shift_q[22];
                  end else begin
                     state_d  = GAP;
                     sync_n_d = 1'b1;
                     mosi_d   = 1'b0;
                     gap_d    = '0;
                  end
               end
            end
         end
         GAP: begin
            sclk_d = 1'b1;
            cnt_d  = tick ? 8'd0 : cnt_q + 8'd1;
            if (tick) begin
               if (gap_q == GAP_W'(GAP_HALFPERIODS - 1)) state_d = IDLE;
               else                                      gap_d   = gap_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         data_q    <= '0;
         shift_q   <= '0;
         clkdiv_q  <= 8'(DEFAULT_DIV);
         div_q     <= 8'(DEFAULT_DIV);
         cnt_q     <= '0;
         bits_q    <= '0;
         gap_q     <= '0;
         sclk_q    <= 1'b1;
         mosi_q    <= 1'b0;
         sync_n_q  <= 1'b1;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
         state_q   <= state_d;
         pending_q <= pending_d;
         data_q    <= data_d;
         shift_q   <= shift_d;
         clkdiv_q  <= clkdiv_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         bits_q    <= bits_d;
         gap_q     <= gap_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         sync_n_q  <= sync_n_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
      end
   end
endmodule

// File: tb/tb_wb_spi_dac.sv
// Directed bench for wb_spi_dac: bus transactions from one initial block, an
// SPI frame monitor, and a queue of expected frames checked as each frame ends.
module tb_wb_spi_dac;
   localparam int CLK_P = 10;

   typedef struct {
      logic [23:0] word;
      int          div;
      int          gap;   // expected SYNC_n high time before this frame, 0 = unchecked
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst_n;
   logic o_spi_sclk, o_spi_mosi, o_spi_sync_n;

   wb_spi_dac_if #(.WB_ADDR_WIDTH(2)) wb_bus ();

   wb_spi_dac #(.WB_ADDR_WIDTH(2), .DEFAULT_DIV(10), .GAP_HALFPERIODS(6)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .wb           (wb_bus),
      .o_spi_sclk   (o_spi_sclk),
      .o_spi_mosi   (o_spi_mosi),
      .o_spi_sync_n (o_spi_sync_n)
   );

   always #(CLK_P / 2) i_clk = ~i_clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        sb[$];

   time         t_fall, t_rise, t_first;
   int          nbits = 0;
   int          last_gap = 0;
   int          frame_starts = 0;
   bit          have_rise = 1'b0;
   logic [23:0] cap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SPI monitor: DAC samples MOSI on falling SCLK while SYNC_n is low.
   always @(negedge o_spi_sync_n) begin
      frame_starts++;
      last_gap = have_rise ? int'(($time - t_rise) / CLK_P) : 0;
      t_fall   = $time;
      nbits    = 0;
      cap      = '0;
   end

   always @(negedge o_spi_sclk) begin
      if (o_spi_sync_n === 1'b0) begin
         if (nbits == 0) t_first = $time;
         cap = {cap[22:0], o_spi_mosi};
         nbits++;
      end
   end

   always @(posedge o_spi_sync_n) begin
      exp_t e;
      if (i_rst_n === 1'b1) begin
         check("frame_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("frame_word", {8'h00, cap}, {8'h00, e.word});
            check("frame_bits", 32'(nbits), 24);
            check("frame_len_clks", 32'(($time - t_fall) / CLK_P), 32'(48 * (e.div + 1)));
            check("sclk_half_clks", 32'((t_first - t_fall) / CLK_P), 32'(e.div + 1));
            if (e.gap != 0) check("gap_clks", 32'(last_gap), 32'(e.gap));
         end
         t_rise    = $time;
         have_rise = 1'b1;
      end
   end

   task automatic wb_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int stalls);
      int n;
      stalls = 0;
      n      = 0;
      @(posedge i_clk); #1;
      wb_bus.i_wb_cyc  = 1'b1;
      wb_bus.i_wb_stb  = 1'b1;
      wb_bus.i_wb_we   = we;
      wb_bus.i_wb_addr = addr;
      wb_bus.i_wb_data = wdata;
      wb_bus.i_wb_sel  = 4'hF;
      @(negedge i_clk);
      while (wb_bus.o_wb_stall && n < 5000) begin
         stalls++;
         n++;
         @(negedge i_clk);
      end
      check("stall_released", wb_bus.o_wb_stall, 0);
      @(posedge i_clk); #1;
      wb_bus.i_wb_cyc = 1'b0;
      wb_bus.i_wb_stb = 1'b0;
      wb_bus.i_wb_we  = 1'b0;
      check("ack", wb_bus.o_wb_ack, 1);
      rdata = wb_bus.o_wb_data;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] wdata);
      logic [31:0] r;
      int          s;
      wb_xfer(1'b1, addr, wdata, r, s);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      int          s;
      wb_xfer(1'b0, addr, 32'd0, r, s);
      check(tag, r, exp);
   endtask

   task automatic wr_frame(input logic [23:0] word, input int div, input int gap);
      exp_t e;
      e.word = word;
      e.div  = div;
      e.gap  = gap;
      sb.push_back(e);
      wr(2'd0, {8'h00, word});
   endtask

   task automatic wait_drained(input int tail);
      int n = 0;
      while (sb.size() != 0 && n < 20000) begin
         @(negedge i_clk);
         n++;
      end
      check("drained", 32'(sb.size()), 0);
      repeat (tail) @(negedge i_clk);
   endtask

   task automatic wait_sync_low();
      int n = 0;
      while (o_spi_sync_n !== 1'b0 && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      check("sync_low_seen", o_spi_sync_n, 0);
   endtask

   initial begin
      logic [31:0] r;
      int          s;
      int          n;
      int          starts_snap;
      exp_t        e;

      wb_bus.i_wb_cyc  = 1'b0;
      wb_bus.i_wb_stb  = 1'b0;
      wb_bus.i_wb_we   = 1'b0;
      wb_bus.i_wb_addr = 2'd0;
      wb_bus.i_wb_data = 32'd0;
      wb_bus.i_wb_sel  = 4'h0;
      i_rst_n = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_sync_n", o_spi_sync_n, 1);
      check("rst_sclk", o_spi_sclk, 1);
      check("rst_mosi", o_spi_mosi, 0);
      check("rst_ack", wb_bus.o_wb_ack, 0);
      check("rst_rdata", wb_bus.o_wb_data, 0);
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);

      // Default divider, first frame and its start latency.
      rd_check("clkdiv_default", 2'd2, 32'd10);
      rd_check("data_after_reset", 2'd0, 32'd0);
      e.word = 24'h007F22; e.div = 10; e.gap = 0;
      sb.push_back(e);
      wb_xfer(1'b1, 2'd0, 32'h0000_7F22, r, s);
      check("sync_n_before_load", o_spi_sync_n, 1);
      @(posedge i_clk); #1;
      check("ack_single", wb_bus.o_wb_ack, 0);
      check("sync_n_after_load", o_spi_sync_n, 0);
      check("mosi_first_bit", o_spi_mosi, 0);
      wait_drained(80);

      // Fastest SCLK.
      wr(2'd2, 32'd0);
      wr_frame(24'hA5A5A5, 0, 0);
      rd_check("clkdiv_zero", 2'd2, 32'd0);
      wait_drained(20);

      // Back-to-back writes: load + pending, then a stalled third write.
      e.word = 24'h111111; e.div = 0; e.gap = 0;
      sb.push_back(e);
      @(posedge i_clk); #1;
      wb_bus.i_wb_cyc  = 1'b1;
      wb_bus.i_wb_stb  = 1'b1;
      wb_bus.i_wb_we   = 1'b1;
      wb_bus.i_wb_addr = 2'd0;
      wb_bus.i_wb_data = 32'h0011_1111;
      @(negedge i_clk);
      check("b2b_stall_1", wb_bus.o_wb_stall, 0);
      @(posedge i_clk); #1;
      check("b2b_ack_1", wb_bus.o_wb_ack, 1);
      e.word = 24'h222222; e.div = 0; e.gap = 7;
      sb.push_back(e);
      wb_bus.i_wb_data = 32'h0022_2222;
      @(negedge i_clk);
      check("b2b_stall_2_on_load", wb_bus.o_wb_stall, 0);
      @(posedge i_clk); #1;
      check("b2b_ack_2", wb_bus.o_wb_ack, 1);
      wb_bus.i_wb_cyc = 1'b0;
      wb_bus.i_wb_stb = 1'b0;
      wb_bus.i_wb_we  = 1'b0;
      @(posedge i_clk); #1;
      check("b2b_no_extra_ack", wb_bus.o_wb_ack, 0);
      rd_check("status_busy_pending", 2'd1, 32'h3);
      e.word = 24'h333333; e.div = 0; e.gap = 7;
      sb.push_back(e);
      wb_xfer(1'b1, 2'd0, 32'h0033_3333, r, s);
      check("third_write_stalled", 32'(s > 0), 1);
      wait_drained(0);
      rd_check("status_in_gap", 2'd1, 32'h1);
      repeat (20) @(negedge i_clk);

      // STATUS through a frame, and the unused register.
      wr(2'd2, 32'd10);
      wr_frame(24'hC3_5A_96, 10, 0);
      wait_sync_low();
      rd_check("status_mid_frame", 2'd1, 32'h1);
      wait_drained(80);
      rd_check("status_idle", 2'd1, 32'h0);
      wr(2'd3, 32'hFFFF_FFFF);
      rd_check("addr3_reads_zero", 2'd3, 32'h0);
      rd_check("data_unchanged", 2'd0, 32'h00C3_5A96);
      rd_check("status_after_addr3", 2'd1, 32'h0);

      // CLKDIV change during a frame applies to the next frame only.
      wr_frame(24'h0F0F0F, 10, 0);
      wait_sync_low();
      wr(2'd2, 32'd3);
      rd_check("clkdiv_readback", 2'd2, 32'd3);
      wr_frame(24'hF0F0F0, 3, 67);
      wait_drained(40);

      // Asynchronous reset in the middle of a frame.
      wr(2'd2, 32'd10);
      wr_frame(24'h5A5A5A, 10, 0);
      wait_sync_low();
      n = 0;
      while (nbits < 12 && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      check("reached_bit12", 32'(nbits >= 12), 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_rst_sync_n", o_spi_sync_n, 1);
      check("async_rst_sclk", o_spi_sclk, 1);
      check("async_rst_mosi", o_spi_mosi, 0);
      check("async_rst_rdata", wb_bus.o_wb_data, 0);
      sb.delete();
      starts_snap = frame_starts;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      rd_check("data_cleared", 2'd0, 32'd0);
      rd_check("clkdiv_restored", 2'd2, 32'd10);
      rd_check("status_after_rst", 2'd1, 32'd0);
      repeat (600) @(negedge i_clk);
      check("no_frame_after_rst", 32'(frame_starts), 32'(starts_snap));

      // Recovery with a fresh write.
      wr_frame(24'h123456, 10, 0);
      wait_drained(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
